// File: rtl/inta_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : inta_sequencer
// Description : Interrupt-acknowledge sequencer. Raises INT, tracks the
//               two-pulse INTA handshake and strobes the in-service logic.
//               Optional macro INTA_AUTO_EOI_EN enables the secondACK strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module inta_sequencer (
    input  logic       clk,
    input  logic       resetN,
    input  logic       intaN,
    input  logic       intReq,
    input  logic [2:0] reqIndex,
    input  logic       aeoiMode,
    output logic       INT,
    output logic       readPriority,
    output logic       sendVector,
    output logic       secondACK,
    output logic [2:0] vectorIndex,
    output logic       spurious,
    output logic       freezeIrr,
    output logic       timeoutErr
);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_REQ  = 3'd1;
    localparam logic [2:0] c_ACK1 = 3'd2;
    localparam logic [2:0] c_GAP  = 3'd3;
    localparam logic [2:0] c_ACK2 = 3'd4;
    localparam logic [2:0] c_DONE = 3'd5;

    localparam logic [7:0] c_COUNT_MAX = 8'hFF;

    logic [2:0] r_state;
    logic [2:0] w_next;
    logic       r_inta_prev;
    logic [7:0] r_count;
    logic       r_read_priority;
    logic       r_send_vector;
    logic       r_second_ack;
    logic       r_spurious;
    logic [2:0] r_vector_index;
    logic       w_fall;
    logic       w_rise;
    logic       w_timed;
    logic       w_expired;
    logic       w_second_ack_set;

    assign w_fall    = r_inta_prev & ~intaN;
    assign w_rise    = ~r_inta_prev & intaN;
    assign w_timed   = (r_state == c_ACK1) || (r_state == c_GAP) || (r_state == c_ACK2);
    assign w_expired = w_timed && (r_count == c_COUNT_MAX);

`ifdef INTA_AUTO_EOI_EN
    assign w_second_ack_set = (r_state == c_ACK2) && (w_next == c_DONE) &&
                              aeoiMode && !r_spurious;
`else
    logic w_unused_aeoi;
    assign w_unused_aeoi    = aeoiMode;
    assign w_second_ack_set = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a saturated counter overrides any pending INTA edge
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: if (intReq) w_next = c_REQ;
            c_REQ: begin
                if (w_fall)       w_next = c_ACK1;
                else if (!intReq) w_next = c_IDLE;
            end
            c_ACK1: begin
                if (w_expired)    w_next = c_IDLE;
                else if (w_rise)  w_next = c_GAP;
            end
            c_GAP: begin
                if (w_expired)    w_next = c_IDLE;
                else if (w_fall)  w_next = c_ACK2;
            end
            c_ACK2: begin
                if (w_expired)    w_next = c_IDLE;
                else if (w_rise)  w_next = c_DONE;
            end
            c_DONE:  w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    // Edge history, timeout counter, latched vector and strobes
    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_inta_prev     <= 1'b1;
            r_count         <= 8'd0;
            r_read_priority <= 1'b0;
            r_send_vector   <= 1'b0;
            r_second_ack    <= 1'b0;
            r_spurious      <= 1'b0;
            r_vector_index  <= 3'd0;
        end else begin
            r_inta_prev     <= intaN;
            r_read_priority <= (r_state == c_REQ) && (w_next == c_ACK1) && intReq;
            r_send_vector   <= (r_state == c_GAP) && (w_next == c_ACK2);
            r_second_ack    <= w_second_ack_set;

            if ((w_next != r_state) || !w_timed) begin
                r_count <= 8'd0;
            end else if (r_count != c_COUNT_MAX) begin
                r_count <= r_count + 8'd1;
            end

            if ((r_state == c_REQ) && (w_next == c_ACK1)) begin
                r_vector_index <= intReq ? reqIndex : 3'd7;
                r_spurious     <= !intReq;
            end else if (w_next == c_IDLE) begin
                r_spurious     <= 1'b0;
            end
        end
    end

    // Output logic
    always_comb begin
        INT          = (r_state == c_REQ);
        freezeIrr    = w_timed || (r_state == c_DONE);
        readPriority = r_read_priority;
        sendVector   = r_send_vector;
        secondACK    = r_second_ack;
        vectorIndex  = r_vector_index;
        spurious     = r_spurious;
        timeoutErr   = w_expired;
    end

endmodule
`default_nettype wire

// File: tb/tb_inta_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_inta_sequencer
// Description : Directed self-checking bench for inta_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inta_sequencer;

    logic       clk;
    logic       resetN;
    logic       intaN;
    logic       intReq;
    logic [2:0] reqIndex;
    logic       aeoiMode;
    logic       INT;
    logic       readPriority;
    logic       sendVector;
    logic       secondACK;
    logic [2:0] vectorIndex;
    logic       spurious;
    logic       freezeIrr;
    logic       timeoutErr;

    int checks = 0;
    int errors = 0;
    int n_rp, n_sv, n_sa, n_to;

`ifdef INTA_AUTO_EOI_EN
    localparam logic c_AEOI_EXP = 1'b1;
`else
    localparam logic c_AEOI_EXP = 1'b0;
`endif

    inta_sequencer dut (
        .clk          (clk),
        .resetN       (resetN),
        .intaN        (intaN),
        .intReq       (intReq),
        .reqIndex     (reqIndex),
        .aeoiMode     (aeoiMode),
        .INT          (INT),
        .readPriority (readPriority),
        .sendVector   (sendVector),
        .secondACK    (secondACK),
        .vectorIndex  (vectorIndex),
        .spurious     (spurious),
        .freezeIrr    (freezeIrr),
        .timeoutErr   (timeoutErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge, then settle and tally strobes
    task automatic cycle();
        @(posedge clk);
        #1;
        n_rp += int'(readPriority);
        n_sv += int'(sendVector);
        n_sa += int'(secondACK);
        n_to += int'(timeoutErr);
    endtask

    task automatic clear_counts();
        n_rp = 0; n_sv = 0; n_sa = 0; n_to = 0;
    endtask

    task automatic do_reset();
        resetN = 1'b0; intaN = 1'b1; intReq = 1'b0; reqIndex = 3'd0; aeoiMode = 1'b0;
        cycle();
        resetN = 1'b1;
        clear_counts();
    endtask

    task automatic test_reset();
        logic [9:0] obs;
        do_reset();
        obs = {INT, readPriority, sendVector, secondACK, vectorIndex, spurious, freezeIrr, timeoutErr};
        checks++;
        if (obs !== 10'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 0000000000", obs);
        end
    endtask

    task automatic test_normal();
        do_reset();
        intReq = 1'b1; reqIndex = 3'd5;
        cycle();
        checks++;
        if (INT !== 1'b1) begin errors++; $display("FAIL normal_int: got %b want 1", INT); end
        cycle(); cycle();
        checks++;
        if (INT !== 1'b1 || freezeIrr !== 1'b0) begin
            errors++; $display("FAIL normal_int_hold: got INT=%b frz=%b want 1 0", INT, freezeIrr);
        end
        intaN = 1'b0;
        cycle();
        checks++;
        if (INT !== 1'b0 || freezeIrr !== 1'b1 || readPriority !== 1'b1 ||
            vectorIndex !== 3'd5 || spurious !== 1'b0) begin
            errors++;
            $display("FAIL normal_ack1: got INT=%b frz=%b rp=%b vi=%0d sp=%b want 0 1 1 5 0",
                     INT, freezeIrr, readPriority, vectorIndex, spurious);
        end
        intReq = 1'b0;
        cycle(); cycle();
        intaN = 1'b1;
        cycle(); cycle(); cycle(); cycle();
        checks++;
        if (n_sv !== 0 || freezeIrr !== 1'b1) begin
            errors++; $display("FAIL normal_gap: got sv=%0d frz=%b want 0 1", n_sv, freezeIrr);
        end
        intaN = 1'b0;
        cycle();
        checks++;
        if (sendVector !== 1'b1) begin errors++; $display("FAIL normal_send: got %b want 1", sendVector); end
        cycle(); cycle();
        intaN = 1'b1;
        cycle();
        checks++;
        if (freezeIrr !== 1'b1 || vectorIndex !== 3'd5) begin
            errors++; $display("FAIL normal_done: got frz=%b vi=%0d want 1 5", freezeIrr, vectorIndex);
        end
        cycle();
        checks++;
        if (freezeIrr !== 1'b0 || INT !== 1'b0 || n_rp !== 1 || n_sv !== 1 || n_sa !== 0) begin
            errors++;
            $display("FAIL normal_idle: got frz=%b INT=%b rp=%0d sv=%0d sa=%0d want 0 0 1 1 0",
                     freezeIrr, INT, n_rp, n_sv, n_sa);
        end
    endtask

    task automatic test_req_withdraw();
        do_reset();
        intReq = 1'b1; reqIndex = 3'd1;
        cycle();
        intReq = 1'b0;
        cycle();
        checks++;
        if (INT !== 1'b0) begin errors++; $display("FAIL withdraw_int: got %b want 0", INT); end
        intaN = 1'b0;
        cycle(); cycle();
        intaN = 1'b1;
        cycle();
        checks++;
        if (freezeIrr !== 1'b0 || n_rp !== 0) begin
            errors++; $display("FAIL withdraw_idle: got frz=%b rp=%0d want 0 0", freezeIrr, n_rp);
        end
    endtask

    task automatic test_spurious();
        do_reset();
        intReq = 1'b1; reqIndex = 3'd3;
        cycle();
        intReq = 1'b0; intaN = 1'b0;
        cycle();
        checks++;
        if (spurious !== 1'b1 || vectorIndex !== 3'd7 || readPriority !== 1'b0 || freezeIrr !== 1'b1) begin
            errors++;
            $display("FAIL spur_ack1: got sp=%b vi=%0d rp=%b frz=%b want 1 7 0 1",
                     spurious, vectorIndex, readPriority, freezeIrr);
        end
        cycle();
        intaN = 1'b1;
        cycle(); cycle();
        intaN = 1'b0;
        cycle();
        checks++;
        if (sendVector !== 1'b1 || spurious !== 1'b1) begin
            errors++; $display("FAIL spur_send: got sv=%b sp=%b want 1 1", sendVector, spurious);
        end
        intaN = 1'b1;
        cycle();
        cycle();
        checks++;
        if (spurious !== 1'b0 || freezeIrr !== 1'b0 || n_rp !== 0 || n_sv !== 1) begin
            errors++;
            $display("FAIL spur_end: got sp=%b frz=%b rp=%0d sv=%0d want 0 0 0 1",
                     spurious, freezeIrr, n_rp, n_sv);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        intReq = 1'b1; reqIndex = 3'd4;
        cycle();
        intaN = 1'b0;
        cycle();
        intReq = 1'b0; intaN = 1'b1;
        cycle();
        checks++;
        if (freezeIrr !== 1'b1 || readPriority !== 1'b0 || n_rp !== 1) begin
            errors++; $display("FAIL b2b_gap: got frz=%b rp=%b nrp=%0d want 1 0 1", freezeIrr, readPriority, n_rp);
        end
        intaN = 1'b0;
        cycle();
        checks++;
        if (sendVector !== 1'b1) begin errors++; $display("FAIL b2b_send: got %b want 1", sendVector); end
        intaN = 1'b1;
        cycle();
        cycle();
        checks++;
        if (freezeIrr !== 1'b0 || n_sv !== 1 || vectorIndex !== 3'd4) begin
            errors++; $display("FAIL b2b_end: got frz=%b sv=%0d vi=%0d want 0 1 4", freezeIrr, n_sv, vectorIndex);
        end
    endtask

    task automatic test_timeout();
        int first_to;
        do_reset();
        intReq = 1'b1; reqIndex = 3'd2;
        cycle();
        intaN = 1'b0;
        cycle();
        intReq = 1'b0; intaN = 1'b1;
        cycle();
        clear_counts();
        first_to = -1;
        for (int i = 1; i <= 300; i++) begin
            cycle();
            if (timeoutErr === 1'b1 && first_to < 0) first_to = i;
            if (i == 256) begin
                checks++;
                if (freezeIrr !== 1'b0 || INT !== 1'b0) begin
                    errors++; $display("FAIL timeout_idle: got frz=%b INT=%b want 0 0", freezeIrr, INT);
                end
            end
        end
        checks++;
        if (first_to !== 255 || n_to !== 1 || n_sv !== 0) begin
            errors++; $display("FAIL timeout_pulse: got at=%0d n=%0d sv=%0d want 255 1 0", first_to, n_to, n_sv);
        end
    endtask

    task automatic test_reset_mid();
        logic [9:0] obs;
        do_reset();
        intReq = 1'b1; reqIndex = 3'd5;
        cycle();
        intaN = 1'b0;
        cycle();
        intReq = 1'b0; intaN = 1'b1;
        cycle();
        resetN = 1'b0;
        cycle();
        resetN = 1'b1;
        obs = {INT, readPriority, sendVector, secondACK, vectorIndex, spurious, freezeIrr, timeoutErr};
        checks++;
        if (obs !== 10'd0) begin errors++; $display("FAIL midreset_outputs: got %b want 0000000000", obs); end
        intaN = 1'b0;
        cycle(); cycle();
        intaN = 1'b1;
        checks++;
        if (n_sv !== 0 || n_to !== 0) begin
            errors++; $display("FAIL midreset_nostrobe: got sv=%0d to=%0d want 0 0", n_sv, n_to);
        end
        intReq = 1'b1; reqIndex = 3'd6;
        cycle(); cycle();
        intaN = 1'b0;
        cycle();
        checks++;
        if (readPriority !== 1'b1 || vectorIndex !== 3'd6 || freezeIrr !== 1'b1) begin
            errors++; $display("FAIL midreset_restart: got rp=%b vi=%0d frz=%b want 1 6 1",
                               readPriority, vectorIndex, freezeIrr);
        end
    endtask

    task automatic test_aeoi();
        do_reset();
        aeoiMode = 1'b1; intReq = 1'b1; reqIndex = 3'd2;
        cycle();
        intaN = 1'b0;
        cycle();
        intReq = 1'b0; intaN = 1'b1;
        cycle();
        intaN = 1'b0;
        cycle();
        checks++;
        if (secondACK !== 1'b0) begin errors++; $display("FAIL aeoi_early: got %b want 0", secondACK); end
        intaN = 1'b1;
        cycle();
        checks++;
        if (secondACK !== c_AEOI_EXP) begin
            errors++; $display("FAIL aeoi_pulse: got %b want %b", secondACK, c_AEOI_EXP);
        end
        cycle(); cycle();
        checks++;
        if (n_sa !== int'(c_AEOI_EXP)) begin
            errors++; $display("FAIL aeoi_count: got %0d want %0d", n_sa, int'(c_AEOI_EXP));
        end
    endtask

    task automatic test_inta_low_at_reset();
        resetN = 1'b0; intaN = 1'b0; intReq = 1'b1; reqIndex = 3'd1; aeoiMode = 1'b0;
        cycle();
        resetN = 1'b1;
        clear_counts();
        cycle(); cycle(); cycle();
        checks++;
        if (INT !== 1'b1 || freezeIrr !== 1'b0 || n_rp !== 0) begin
            errors++; $display("FAIL lowrst_wait: got INT=%b frz=%b rp=%0d want 1 0 0", INT, freezeIrr, n_rp);
        end
        intaN = 1'b1;
        cycle();
        intaN = 1'b0;
        cycle();
        checks++;
        if (freezeIrr !== 1'b1 || readPriority !== 1'b1 || vectorIndex !== 3'd1) begin
            errors++; $display("FAIL lowrst_ack1: got frz=%b rp=%b vi=%0d want 1 1 1",
                               freezeIrr, readPriority, vectorIndex);
        end
    endtask

    initial begin
        resetN = 1'b0; intaN = 1'b1; intReq = 1'b0; reqIndex = 3'd0; aeoiMode = 1'b0;
        clear_counts();
        test_reset();
        test_normal();
        test_req_withdraw();
        test_spurious();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_aeoi();
        test_inta_low_at_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/inta_sequencer.md
INTA_SEQUENCER -- requirements
Module: inta_sequencer

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port resetN, input, 1, synchronous active-low reset, sampled on rising clk.
REQ-003 SHALL have port intaN, input, 1, CPU interrupt-acknowledge strobe, active low, already synchronous to clk.
REQ-004 SHALL have port intReq, input, 1, high while the priority resolver holds an unmasked pending request.
REQ-005 SHALL have port reqIndex, input, 3, IR number of the highest-priority pending request.
REQ-006 SHALL have port aeoiMode, input, 1, ICW4 AEOI bit, sampled in ACK2.
REQ-007 SHALL have port INT, output, 1, interrupt request to CPU.
REQ-008 SHALL have ports readPriority, sendVector and secondACK, each output, 1, one-cycle strobes to the in-service register.
REQ-009 SHALL have port vectorIndex, output, 3, IR index latched at first INTA.
REQ-010 SHALL have port spurious, output, 1, high when the current cycle is a spurious IR7 acknowledge.
REQ-011 SHALL have port freezeIrr, output, 1, high from first INTA falling edge until sequence end.
REQ-012 SHALL have port timeoutErr, output, 1, one-cycle strobe on aborted sequence.

Function
REQ-013 SHALL register intaN into intaPrev (reset value 1); fall = intaPrev & ~intaN; rise = ~intaPrev & intaN.
REQ-014 SHALL implement states IDLE, REQ, ACK1, GAP, ACK2, DONE.
REQ-015 IDLE: INT=0; go to REQ when intReq=1; any intaN edge is ignored.
REQ-016 REQ: INT=1; on fall go to ACK1, latch vectorIndex=reqIndex when intReq=1, else vectorIndex=7 and spurious=1.
REQ-017 The REQ->ACK1 transition SHALL pulse readPriority for exactly one cycle, only when not spurious.
REQ-018 REQ: if intReq drops before any fall, SHALL return to IDLE with INT=0 next cycle.
REQ-019 ACK1: INT=0, freezeIrr=1; on rise go to GAP.
REQ-020 GAP: on fall go to ACK2 and pulse sendVector for one cycle (also when spurious).
REQ-021 ACK2: on rise go to DONE.
REQ-022 DONE: exactly one cycle; go to IDLE; freezeIrr, spurious and vectorIndex hold until the IDLE entry.
REQ-023 SHALL run an 8-bit timeout counter, cleared on every state change, incremented each cycle in ACK1, GAP and ACK2, saturating at 255.
REQ-024 When the counter reaches 255 in ACK1, GAP or ACK2, SHALL go to IDLE next cycle, pulse timeoutErr, and clear freezeIrr and spurious.
REQ-025 SHALL produce at most one readPriority and one sendVector per sequence, with no strobe asserted in IDLE.
REQ-026 A fall and rise seen in consecutive cycles SHALL each be honoured; the state advances at most one step per cycle.

Reset
REQ-027 With resetN=0 at a clk edge, next state SHALL be IDLE, regardless of current state.
REQ-028 At the same edge, all outputs SHALL be 0 and vectorIndex=0.
REQ-029 At the same edge, the counter SHALL be 0 and intaPrev=1.
REQ-030 Reset mid-sequence SHALL abort without any strobe, including timeoutErr.

Configuration
REQ-031 Macro INTA_AUTO_EOI_EN defined: on the ACK2->DONE transition with aeoiMode=1 and not spurious, SHALL pulse secondACK for one cycle.
REQ-032 Macro INTA_AUTO_EOI_EN undefined: secondACK SHALL be tied 0 and aeoiMode ignored; EOI comes only from OCW2.

Verification
REQ-033 intReq=1, reqIndex=5, two INTA pulses 3 cycles low / 4 cycles high -> INT until first fall, readPriority once, vectorIndex=5, sendVector once at second fall, IDLE 1 cycle after DONE.
REQ-034 intReq falls the cycle before first INTA fall -> spurious=1, vectorIndex=7, no readPriority, sendVector once.
REQ-035 First INTA, then intaN held high 300 cycles -> timeoutErr pulse 255 cycles after GAP entry; state IDLE; freezeIrr=0.
REQ-036 resetN=0 for one cycle while in GAP -> all outputs 0 next cycle, no sendVector, new sequence starts correctly.
REQ-037 INTA_AUTO_EOI_EN defined, aeoiMode=1, reqIndex=2 -> secondACK one cycle at second rise; macro undefined -> secondACK stays 0.
REQ-038 intReq=1 with intaN already low at reset release -> no ACK1 until intaN rises and falls again.
